// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller with RUN/MEMWAIT/TRAP FSM and saturating perf counters.
// Define PIPE_CTRL_OVERFLOW_TRAP_EN to let MEM-stage arithmetic overflow raise a trap.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_BranchTaken,
    input  logic             MEM_Overflow,
    input  logic             MEM_OverflowEn,
    input  logic             MEM_Req,
    input  logic             Mem_Ready,
    input  logic             Cnt_clr,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_stall,
    output logic             MEM_WB_flush,
    output logic [1:0]       PC_sel,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_MEMWAIT = 2'b01;
    localparam logic [1:0] ST_TRAP    = 2'b10;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_TRAP   = 2'b10;

    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_ovf_trap;
    logic              w_timeout;
    logic              w_load_use;
    logic              w_mem_miss;
    logic [1:0]        w_next_state;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_count_flush;
    logic              w_pc_stall;
    logic              w_if_id_stall;
    logic              w_id_ex_stall;
    logic              w_ex_mem_stall;
    logic              w_mem_wb_stall;
    logic              w_if_id_flush;
    logic              w_id_ex_flush;
    logic              w_ex_mem_flush;
    logic              w_mem_wb_flush;
    logic [1:0]        w_pc_sel;
    logic              w_active;

`ifdef PIPE_CTRL_OVERFLOW_TRAP_EN
    assign w_ovf_trap = MEM_Overflow & MEM_OverflowEn;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = MEM_Overflow ^ MEM_OverflowEn;
    assign w_ovf_trap   = 1'b0;
`endif

    assign w_timeout  = (r_wait_cnt == TIMEOUT_VAL);
    assign w_mem_miss = MEM_Req & ~Mem_Ready;
    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign w_load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                        ((ID_UsesRs && (ID_Rs == EX_Rd)) ||
                         (ID_UsesRt && (ID_Rt == EX_Rd)));

    always_comb begin
        w_next_state   = r_state;
        w_wait_next    = r_wait_cnt;
        w_count_flush  = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_mem_wb_stall = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_flush = 1'b0;
        w_pc_sel       = SEL_SEQ;
        case (r_state)
            ST_RUN: begin
                if (w_ovf_trap) begin
                    {w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush} = 4'b1111;
                    w_pc_sel     = SEL_TRAP;
                    w_next_state = ST_TRAP;
                    w_wait_next  = '0;
                end else if (MEM_BranchTaken) begin
                    {w_if_id_flush, w_id_ex_flush, w_ex_mem_flush} = 3'b111;
                    w_pc_sel      = SEL_BRANCH;
                    w_count_flush = 1'b1;
                end else if (w_mem_miss) begin
                    {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = 4'b1111;
                    w_mem_wb_flush = 1'b1;
                    w_next_state   = ST_MEMWAIT;
                    w_wait_next    = WAIT_W'(1);
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                // Completion beats the timeout: a response arriving on the last allowed cycle is kept.
                if (w_ovf_trap || (!Mem_Ready && w_timeout)) begin
                    {w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush} = 4'b1111;
                    w_pc_sel     = SEL_TRAP;
                    w_next_state = ST_TRAP;
                    w_wait_next  = '0;
                end else if (Mem_Ready) begin
                    w_next_state = ST_RUN;
                    w_wait_next  = '0;
                end else begin
                    {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = 4'b1111;
                    w_mem_wb_flush = 1'b1;
                    w_wait_next    = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_TRAP: begin
                {w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush} = 4'b1111;
                w_pc_stall   = 1'b1;
                w_next_state = ST_RUN;
                w_wait_next  = '0;
            end
            default: begin
                w_next_state = ST_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    // Controls are held quiet during reset; within a segment a flush masks any stall.
    assign w_active     = ~Reset;
    assign PC_stall     = w_active & w_pc_stall;
    assign IF_ID_flush  = w_active & w_if_id_flush;
    assign ID_EX_flush  = w_active & w_id_ex_flush;
    assign EX_MEM_flush = w_active & w_ex_mem_flush;
    assign MEM_WB_flush = w_active & w_mem_wb_flush;
    assign IF_ID_stall  = w_active & w_if_id_stall  & ~w_if_id_flush;
    assign ID_EX_stall  = w_active & w_id_ex_stall  & ~w_id_ex_flush;
    assign EX_MEM_stall = w_active & w_ex_mem_stall & ~w_ex_mem_flush;
    assign MEM_WB_stall = w_active & w_mem_wb_stall & ~w_mem_wb_flush;
    assign PC_sel       = w_active ? w_pc_sel : SEL_SEQ;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (Cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (PC_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_count_flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign State     = r_state;
    assign Stall_cnt = r_stall_cnt;
    assign Flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected controls, a monitor compares.
// Honours PIPE_CTRL_OVERFLOW_TRAP_EN for the overflow-versus-branch vectors.
module tb_pipe_ctrl;

    localparam int CNT_W = 3;

    // {PC_stall, IF_ID/ID_EX/EX_MEM/MEM_WB stall, IF_ID/ID_EX/EX_MEM/MEM_WB flush, PC_sel}
    localparam logic [10:0] C_NONE = 11'b00000_0000_00;
    localparam logic [10:0] C_LU   = 11'b11000_0100_00;
    localparam logic [10:0] C_BR   = 11'b00000_1110_01;
    localparam logic [10:0] C_MW   = 11'b11110_0001_00;
    localparam logic [10:0] C_TRP  = 11'b00000_1111_10;
    localparam logic [10:0] C_TST  = 11'b10000_1111_00;

`ifdef PIPE_CTRL_OVERFLOW_TRAP_EN
    localparam logic [10:0] OV_CTL23 = C_TRP;
    localparam logic [10:0] OV_CTL24 = C_TST;
    localparam logic [1:0]  OV_ST24  = 2'b10;
    localparam logic [7:0]  OV_FC24  = 8'd0;
`else
    localparam logic [10:0] OV_CTL23 = C_BR;
    localparam logic [10:0] OV_CTL24 = C_NONE;
    localparam logic [1:0]  OV_ST24  = 2'b00;
    localparam logic [7:0]  OV_FC24  = 8'd1;
`endif

    logic             Clk;
    logic             Reset;
    logic [4:0]       ID_Rs, ID_Rt, EX_Rd;
    logic             ID_UsesRs, ID_UsesRt, EX_MemRead;
    logic             MEM_BranchTaken, MEM_Overflow, MEM_OverflowEn;
    logic             MEM_Req, Mem_Ready, Cnt_clr;
    logic             PC_stall;
    logic             IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic             EX_MEM_stall, EX_MEM_flush, MEM_WB_stall, MEM_WB_flush;
    logic [1:0]       PC_sel, State;
    logic [CNT_W-1:0] Stall_cnt, Flush_cnt;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
        .MEM_BranchTaken(MEM_BranchTaken), .MEM_Overflow(MEM_Overflow),
        .MEM_OverflowEn(MEM_OverflowEn), .MEM_Req(MEM_Req), .Mem_Ready(Mem_Ready),
        .Cnt_clr(Cnt_clr), .PC_stall(PC_stall),
        .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_stall(EX_MEM_stall), .EX_MEM_flush(EX_MEM_flush),
        .MEM_WB_stall(MEM_WB_stall), .MEM_WB_flush(MEM_WB_flush),
        .PC_sel(PC_sel), .State(State), .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [10:0] ctl;
        logic [1:0]  st;
        logic [7:0]  sc;
        logic [7:0]  fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [7:0] id, input logic [10:0] got,
                         input logic [10:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL v%0d %s: got %b expected %b", id, nm, got, want);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctl", e.id, {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                                IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, PC_sel},
                  e.ctl);
            check("state", e.id, 11'(State), 11'(e.st));
            check("stall_cnt", e.id, 11'(Stall_cnt), 11'(e.sc));
            check("flush_cnt", e.id, 11'(Flush_cnt), 11'(e.fc));
        end
    end

    task automatic step(input logic rst, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic ld,
                        input logic [4:0] rd, input logic br, input logic ovf,
                        input logic ovfen, input logic req, input logic rdy, input logic clr,
                        input logic [10:0] ectl, input logic [1:0] est,
                        input logic [7:0] esc, input logic [7:0] efc);
        exp_t x;
        @(posedge Clk);
        #1;
        Reset = rst; ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt;
        EX_MemRead = ld; EX_Rd = rd; MEM_BranchTaken = br;
        MEM_Overflow = ovf; MEM_OverflowEn = ovfen;
        MEM_Req = req; Mem_Ready = rdy; Cnt_clr = clr;
        vec_id++;
        x.id = 8'(vec_id); x.ctl = ectl; x.st = est; x.sc = esc; x.fc = efc;
        exp_q.push_back(x);
    endtask

    initial begin
        Reset = 1'b1; ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0;
        EX_MemRead = 0; EX_Rd = '0; MEM_BranchTaken = 0; MEM_Overflow = 0;
        MEM_OverflowEn = 0; MEM_Req = 0; Mem_Ready = 0; Cnt_clr = 0;

        //   rst rs  urs rt  urt ld rd  br ov oe rq rdy clr  ctl     st     sc  fc
        step(1, 5'd0,0, 5'd0,0, 0,5'd0, 1, 0,0, 0,0, 0, C_NONE, 2'b00, 0, 0);  // 1 reset hides branch
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 0, 0);  // 2 idle
        step(0, 5'd5,1, 5'd0,0, 1,5'd5, 0, 0,0, 0,0, 0, C_LU,   2'b00, 0, 0);  // 3 load-use Rs
        step(0, 5'd5,1, 5'd0,0, 1,5'd0, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 1, 0);  // 4 Rd=0
        step(0, 5'd5,0, 5'd7,1, 1,5'd7, 0, 0,0, 0,0, 0, C_LU,   2'b00, 1, 0);  // 5 load-use Rt
        step(0, 5'd5,0, 5'd7,0, 1,5'd7, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 2, 0);  // 6 Rt unused
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 1, 0,0, 0,0, 0, C_BR,   2'b00, 2, 0);  // 7 branch
        step(0, 5'd5,1, 5'd0,0, 1,5'd5, 1, 0,0, 0,0, 0, C_BR,   2'b00, 2, 1);  // 8 branch > load-use
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 1, C_NONE, 2'b00, 2, 2);  // 9 clear counters
        step(0, 5'd5,1, 5'd0,0, 1,5'd5, 0, 0,0, 1,0, 0, C_MW,   2'b00, 0, 0);  // 10 miss > load-use
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 1, 0);  // 11 wait 1
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 2, 0);  // 12 wait 2
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 3, 0);  // 13 wait 3
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,1, 0, C_NONE, 2'b01, 4, 0);  // 14 ready beats timeout
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 4, 0);  // 15 back in RUN
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b00, 4, 0);  // 16 miss
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 5, 0);  // 17
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 6, 0);  // 18
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 7, 0);  // 19 counter saturates
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_TRP,  2'b01, 7, 0);  // 20 timeout trap
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 1, 0,0, 1,0, 0, C_TST,  2'b10, 7, 0);  // 21 TRAP ignores inputs
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 7, 0);  // 22 RUN
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 1, 1,1, 0,0, 0, OV_CTL23, 2'b00, 7, 0);      // 23 ovf + branch
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 0, OV_CTL24, OV_ST24, 7, OV_FC24); // 24
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 1, C_NONE, 2'b00, 7, OV_FC24); // 25 clear
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 1,0, 0,0, 0, C_NONE, 2'b00, 0, 0);  // 26 ovf not enabled
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b00, 0, 0);  // 27 miss
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_MW,   2'b01, 1, 0);  // 28 wait
        step(1, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 1,0, 0, C_NONE, 2'b00, 0, 0);  // 29 reset mid-wait
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 0, 0);  // 30 nothing pending
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 1, 0,0, 0,0, 0, C_BR,   2'b00, 0, 0);  // 31 branch after reset
        step(0, 5'd0,0, 5'd0,0, 0,5'd0, 0, 0,0, 0,0, 0, C_NONE, 2'b00, 0, 1);  // 32

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
